mem_ctrl: RTL and testbench

Main-memory controller behind the instruction/data memory arbiter. It accepts one cache-line transaction at a time from the arbiter's granted request and holds it for a fixed access latency. It then performs the line read or write on an internal backing store and returns a single-cycle response. It is the only sequencer of main memory, so both caches see the same deterministic latency.

---
 rtl/mem_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// brisc_pkg / mem_ctrl
//
// Main-memory controller sitting behind the instruction/data memory arbiter.
// Accepts one cache-line transaction at a time, holds it for MEM_LATENCY
// cycles, performs the line read or write on an internal backing store and
// returns a one-cycle response. Every access sees the same fixed latency.
//
// Optional feature macro: MEM_CTRL_ERR_EN
//   defined   : full line index is checked against MEM_LINES; out-of-range
//               accesses leave the store untouched, return zero data and
//               raise resp_err with resp_valid.
//   undefined : line index wraps modulo MEM_LINES, resp_err is constant 0.
//
// Parameters
//   MEM_LATENCY  cycles from acceptance to response (1..255)
//   MEM_LINES    backing-store depth in lines (power of two)
//
// Ports
//   clk         in   clock, rising edge
//   reset_n     in   synchronous active-low reset
//   mem_req     in   transaction request from the arbiter
//   mem_write   in   1 = line write, 0 = line read
//   mem_addr    in   byte address, line-offset bits ignored
//   mem_data    in   write line
//   busy        out  high whenever the controller is not idle
//   resp_valid  out  one-cycle response strobe (reads and writes)
//   resp_data   out  read line, or the written line on a write ack
//   resp_err    out  address error, qualified by resp_valid
// ---------------------------------------------------------------------------

package brisc_pkg;
  parameter int ADDRESS_WIDTH    = 32;
  parameter int CACHE_LINE_WIDTH = 128;
endpackage

module mem_ctrl
  import brisc_pkg::*;
#(
  parameter int MEM_LATENCY = 5,
  parameter int MEM_LINES   = 1024
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        mem_req,
  input  logic                        mem_write,
  input  logic [ADDRESS_WIDTH-1:0]    mem_addr,
  input  logic [CACHE_LINE_WIDTH-1:0] mem_data,
  output logic                        busy,
  output logic                        resp_valid,
  output logic [CACHE_LINE_WIDTH-1:0] resp_data,
  output logic                        resp_err
);

  localparam int OFF     = $clog2(CACHE_LINE_WIDTH / 8);
  localparam int IDX_W   = $clog2(MEM_LINES);
`ifdef MEM_CTRL_ERR_EN
  // Keep the whole line number so out-of-range addresses can be detected.
  localparam int LINE_W  = ADDRESS_WIDTH - OFF;
`else
  localparam int LINE_W  = IDX_W;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic [7:0]                  r_cnt;
  logic                        r_write;
  logic [LINE_W-1:0]           r_line;
  logic [CACHE_LINE_WIDTH-1:0] r_data;
  logic [CACHE_LINE_WIDTH-1:0] r_resp_data;

  logic                        w_accept;
  logic                        w_access;
  logic [IDX_W-1:0]            w_idx;
  logic                        w_oob;

  // Backing store starts out all-zero and survives reset.
  logic [CACHE_LINE_WIDTH-1:0] r_store [MEM_LINES] = '{default: '0};

  assign w_accept = (r_state == IDLE) && mem_req;
  assign w_access = (r_state == BUSY) && (r_cnt == 8'd0);
  assign w_idx    = r_line[IDX_W-1:0];

`ifdef MEM_CTRL_ERR_EN
  logic r_resp_err;
  logic w_unused_addr;

  assign w_oob         = (r_line >= LINE_W'(MEM_LINES));
  assign w_unused_addr = ^mem_addr[OFF-1:0];
`else
  logic w_unused_addr;

  assign w_oob         = 1'b0;
  // Upper address bits are discarded: the index wraps modulo MEM_LINES.
  assign w_unused_addr = ^{mem_addr[ADDRESS_WIDTH-1:OFF+IDX_W], mem_addr[OFF-1:0]};
`endif

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (mem_req) w_next_state = BUSY;
      BUSY:    if (r_cnt == 8'd0) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register, latency counter and captured transaction.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: non-blocking assignments for all clocked state to avoid ordering races.
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_write <= 1'b0;
      r_line  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_cnt   <= 8'(MEM_LATENCY - 1);
        r_write <= mem_write;
        r_line  <= mem_addr[OFF+LINE_W-1:OFF];
        r_data  <= mem_data;
      end else if ((r_state == BUSY) && (r_cnt != 8'd0)) begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

  // Response data: updated only on the access edge, held otherwise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_resp_data <= '0;
    end else if (w_access) begin
      if (w_oob)        r_resp_data <= '0;
      else if (r_write) r_resp_data <= r_data;
      else              r_resp_data <= r_store[w_idx];
    end
  end

  // NOTE: the store has no reset branch; reset only gates the write enable so an
  // access interrupted by reset never modifies memory.
  always_ff @(posedge clk) begin
    if (reset_n && w_access && r_write && !w_oob) begin
      r_store[w_idx] <= r_data;
    end
  end

`ifdef MEM_CTRL_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset_n)      r_resp_err <= 1'b0;
    else if (w_access) r_resp_err <= w_oob;
  end

  assign resp_err = r_resp_err && (r_state == RESP);
`else
  assign resp_err = 1'b0;
`endif

  assign busy       = (r_state != IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_data  = r_resp_data;

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl
//
// Self-checking bench for mem_ctrl. Directed scenarios (write/read, input
// changes while busy, back-to-back requests, reset mid-write, out-of-range
// address, latency 1) followed by randomized transactions. Expected values
// come from a line-array model indexed by address arithmetic. Follows the
// MEM_CTRL_ERR_EN macro for out-of-range expectations.
// ---------------------------------------------------------------------------

module tb_mem_ctrl;
  import brisc_pkg::*;

  localparam int LAT   = 5;
  localparam int LINES = 1024;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         mem_req;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [127:0] mem_data;
  logic         busy;
  logic         resp_valid;
  logic [127:0] resp_data;
  logic         resp_err;

  // Second instance with latency 1.
  logic         req1;
  logic         write1;
  logic [31:0]  addr1;
  logic [127:0] data1;
  logic         busy1;
  logic         rv1;
  logic [127:0] rd1;
  logic         re1;

  int vectors     = 0;
  int miscompares = 0;

  logic [127:0] model [LINES];

  always #5 clk = ~clk;

  mem_ctrl #(.MEM_LATENCY(LAT), .MEM_LINES(LINES)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  mem_ctrl #(.MEM_LATENCY(1), .MEM_LINES(LINES)) dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_req    (req1),
    .mem_write  (write1),
    .mem_addr   (addr1),
    .mem_data   (data1),
    .busy       (busy1),
    .resp_valid (rv1),
    .resp_data  (rd1),
    .resp_err   (re1)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: map a byte address to (line index, error) from the address rules.
  function automatic void map_addr(input logic [31:0] addr, output int idx, output bit err);
    int unsigned line;
    line = addr >> 4;
`ifdef MEM_CTRL_ERR_EN
    err = (line >= LINES);
    idx = err ? 0 : int'(line);
`else
    err = 1'b0;
    idx = int'(line % LINES);
`endif
  endfunction

  // One full transaction on the latency-5 instance, with inputs scrambled while busy.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [127:0] data,
                     input logic [31:0] alt_addr);
    int           idx;
    bit           err;
    logic [127:0] exp_data;
    map_addr(addr, idx, err);
    if (err)     exp_data = '0;
    else if (wr) exp_data = data;
    else         exp_data = model[idx];

    @(negedge clk);
    mem_req = 1'b1; mem_write = wr; mem_addr = addr; mem_data = data;
    @(negedge clk);
    mem_req = 1'b0; mem_write = ~wr; mem_addr = alt_addr; mem_data = rnd128();
    for (int k = 1; k <= LAT + 1; k++) begin
      if (k > 1) @(negedge clk);
      check("busy_during_txn", 128'(busy), 128'(1'b1));
      check("resp_valid_timing", 128'(resp_valid), 128'(k == LAT + 1));
    end
    check("resp_data", resp_data, exp_data);
    check("resp_err", 128'(resp_err), 128'(err));
    if (wr && !err) model[idx] = data;
    @(negedge clk);
    check("busy_after_resp", 128'(busy), 128'(1'b0));
    check("resp_valid_after_resp", 128'(resp_valid), 128'(1'b0));
    check("resp_data_held", resp_data, exp_data);
  endtask

  initial begin
    int           t_pulse [2];
    int           n_pulse;
    logic [127:0] line_a;
    logic [31:0]  a;

    for (int i = 0; i < LINES; i++) model[i] = '0;
    reset_n = 1'b0; mem_req = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_data = '0;
    req1 = 1'b0; write1 = 1'b0; addr1 = '0; data1 = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_resp_valid", 128'(resp_valid), 128'(1'b0));
    check("rst_resp_err", 128'(resp_err), 128'(1'b0));
    check("rst_resp_data", resp_data, 128'(0));
    reset_n = 1'b1;

    // Write 0x40 then read 0x4C (same line).
    txn(1'b1, 32'h40, {4{32'h1111_1111}}, 32'h0);
    txn(1'b0, 32'h4C, '0, 32'h0);

    // Address/data changes during BUSY must not matter.
    txn(1'b1, 32'h80, {4{32'h2222_2222}}, 32'h0);
    txn(1'b0, 32'h40, '0, 32'h80);
    txn(1'b1, 32'h40, {4{32'h3333_3333}}, 32'h80);
    txn(1'b0, 32'h80, '0, 32'h40);

    // mem_req held through RESP: second transaction, pulses 7 cycles apart.
    line_a  = model[4];
    n_pulse = 0;
    @(negedge clk);
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = 32'h40;
    for (int t = 0; t < 40 && n_pulse < 2; t++) begin
      @(negedge clk);
      if (resp_valid) begin
        check("b2b_data", resp_data, line_a);
        t_pulse[n_pulse] = t;
        n_pulse++;
      end
    end
    mem_req = 1'b0;
    check("b2b_pulse_count", 128'(n_pulse), 128'(2));
    if (n_pulse == 2) check("b2b_spacing", 128'(t_pulse[1] - t_pulse[0]), 128'(LAT + 2));
    repeat (LAT + 3) @(negedge clk);
    check("b2b_idle", 128'(busy), 128'(1'b0));

    // Reset on the third BUSY cycle of a write to 0x100: write abandoned.
    @(negedge clk);
    mem_req = 1'b1; mem_write = 1'b1; mem_addr = 32'h100; mem_data = {4{32'hAAAA_AAAA}};
    @(negedge clk);
    mem_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 128'(busy), 128'(1'b0));
    check("midrst_resp_valid", 128'(resp_valid), 128'(1'b0));
    check("midrst_resp_data", resp_data, 128'(0));
    reset_n = 1'b1;
    txn(1'b0, 32'h100, '0, 32'h0);
    check("midrst_store_clean", model[16], 128'(0));

    // Out-of-range line 1024: wraps to line 0, or errors with the feature on.
    txn(1'b1, 32'h0, rnd128(), 32'h0);
    txn(1'b0, 32'h4000, '0, 32'h0);
    txn(1'b1, 32'h4000, rnd128(), 32'h0);
    txn(1'b0, 32'h0, '0, 32'h0);

    // Latency-1 instance.
    line_a = rnd128();
    @(negedge clk);
    req1 = 1'b1; write1 = 1'b1; addr1 = 32'h40; data1 = line_a;
    @(negedge clk);
    req1 = 1'b0; addr1 = 32'h80; data1 = '0;
    check("lat1_busy", 128'(busy1), 128'(1'b1));
    check("lat1_rv_early", 128'(rv1), 128'(1'b0));
    @(negedge clk);
    check("lat1_rv", 128'(rv1), 128'(1'b1));
    check("lat1_data", rd1, line_a);
    check("lat1_err", 128'(re1), 128'(1'b0));
    @(negedge clk);
    check("lat1_idle", 128'(busy1), 128'(1'b0));
    check("lat1_rv_drop", 128'(rv1), 128'(1'b0));

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(3))
        0, 1:    a = ($urandom_range(31) << 4) | $urandom_range(15);
        2:       a = $urandom();
        default: a = ($urandom_range(1020, 1028) << 4) | $urandom_range(15);
      endcase
      txn(1'($urandom_range(1)), a, rnd128(), $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
